// File: rtl/addsub_nibble_sequencer.sv
// Nibble-serial add/subtract controller driving an external 4-bit combinational add/sub slice.
// Optional zero-result flag port enabled by defining ADDSUB_SEQ_ZERO_FLAG_EN.
module addsub_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // the initiator holds valid and its payload stable until that edge.
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_sub,
  output logic [3:0]             sl_a,
  output logic [3:0]             sl_b,
  output logic                   sl_m,
  output logic                   sl_cin,
  input  logic [3:0]             sl_s,
  input  logic                   sl_cout,
  input  logic                   sl_v,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry,
  output logic                   overflow
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  ,
  output logic                   zero
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // state_q is the observable FSM state for checkers.
  state_e          state_q;
  logic [W-1:0]    a_sh_q;
  logic [W-1:0]    b_sh_q;
  logic            op_q;
  logic            carry_reg_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    result_q;
  logic            carry_q;
  logic            overflow_q;
  logic [W-1:0]    result_d;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  logic            zero_q;
`endif

  // Slice sums enter at the MSB so the first nibble ends up at the bottom after NIBBLES shifts.
  generate
    if (NIBBLES == 1) begin : g_one
      assign result_d = sl_s;
    end else begin : g_many
      assign result_d = {sl_s, result_q[W-1:4]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      op_q        <= 1'b0;
      carry_reg_q <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_sh_q      <= in_a;
            b_sh_q      <= in_b;
            op_q        <= in_sub;
            carry_reg_q <= in_sub;  // +1 of two's complement for subtract
            idx_q       <= '0;
            state_q     <= S_RUN;
          end
        end
        S_RUN: begin
          result_q    <= result_d;
          carry_reg_q <= sl_cout;
          a_sh_q      <= a_sh_q >> 4;
          b_sh_q      <= b_sh_q >> 4;
          if (idx_q == LAST_IDX) begin
            idx_q      <= '0;
            carry_q    <= sl_cout;
            overflow_q <= sl_v;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
            zero_q     <= (result_d == '0);
`endif
            state_q    <= S_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    sl_a      = (state_q == S_RUN) ? a_sh_q[3:0] : 4'h0;
    sl_b      = (state_q == S_RUN) ? b_sh_q[3:0] : 4'h0;
    sl_cin    = (state_q == S_RUN) ? carry_reg_q : 1'b0;
    sl_m      = op_q;
    result    = result_q;
    carry     = carry_q;
    overflow  = overflow_q;
  end

`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_addsub_nibble_sequencer.sv
// Bench for addsub_nibble_sequencer with a behavioural 4-bit add/sub slice and a result scoreboard.
// Build with ADDSUB_SEQ_ZERO_FLAG_EN defined to cover the zero flag as well.
module tb_addsub_nibble_sequencer;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int EW      = W + 3;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  localparam bit ZEN = 1'b1;
`else
  localparam bit ZEN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic [3:0]   sl_a, sl_b, sl_s;
  logic         sl_m, sl_cin, sl_cout, sl_v;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry, overflow;
  logic         zero_w;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  logic         zero;
  assign zero_w = zero;
`else
  assign zero_w = 1'b0;
`endif

  logic [EW-1:0] exp_q[$];
  int tests_run = 0;
  int failed    = 0;

  addsub_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .sl_a(sl_a), .sl_b(sl_b), .sl_m(sl_m), .sl_cin(sl_cin),
    .sl_s(sl_s), .sl_cout(sl_cout), .sl_v(sl_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow)
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural 4-bit add/sub slice: s = a + (b ^ m) + c_in
  logic [3:0] bx;
  logic [4:0] sum5;
  always_comb begin
    bx      = sl_b ^ {4{sl_m}};
    sum5    = {1'b0, sl_a} + {1'b0, bx} + {4'b0, sl_cin};
    sl_s    = sum5[3:0];
    sl_cout = sum5[4];
    sl_v    = (sl_a[3] == bx[3]) && (sum5[3] != sl_a[3]);
  end

  function automatic logic [EW-1:0] pack_exp(input logic [W-1:0] res, input logic c, input logic v);
    logic z;
    z = ZEN ? (res == '0) : 1'b0;
    return {z, v, c, res};
  endfunction

  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   s;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    return pack_exp(s[W-1:0], s[W], (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]));
  endfunction

  // Driver tasks
  task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int waited;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    tests_run++;
    if (!in_ready) begin
      failed++;
      $display("FAIL req_accept: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // lat counts clocks from the accept edge (1) to the edge that raises out_valid.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_out(input string name);
    logic [EW-1:0] exp;
    logic [EW-1:0] obs;
    obs = {zero_w, overflow, carry, result};
    tests_run++;
    if (!out_valid) begin
      failed++;
      $display("FAIL %s: out_valid=0, required 1", name);
    end else if (exp_q.size() == 0) begin
      failed++;
      $display("FAIL %s: unexpected result %h with empty scoreboard", name, obs);
    end else begin
      exp = exp_q.pop_front();
      if (obs !== exp) begin
        failed++;
        $display("FAIL %s: {zero,ovf,carry,result}=%h, required %h", name, obs, exp);
      end
    end
  endtask

  task automatic pulse_ready;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    logic [W+14:0] obs;
    logic [W+14:0] exp;
    obs = {in_ready, out_valid, result, carry, overflow, sl_a, sl_b, sl_m, sl_cin, zero_w};
    exp = {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    tests_run++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: outputs=%h, required %h", name, obs, exp);
    end
  endtask

  task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [EW-1:0] exp, input string name, input int hold);
    int lat;
    drive_req(a, b, sub);
    exp_q.push_back(exp);
    tests_run++;
    if ({in_ready, sl_a, sl_b, sl_m, sl_cin} !== {1'b0, a[3:0], b[3:0], sub, sub}) begin
      failed++;
      $display("FAIL %s_first_nibble: {in_ready,sl_a,sl_b,sl_m,sl_cin}=%h, required %h", name,
               {in_ready, sl_a, sl_b, sl_m, sl_cin}, {1'b0, a[3:0], b[3:0], sub, sub});
    end
    wait_out(lat);
    tests_run++;
    if (lat != NIBBLES + 1) begin
      failed++;
      $display("FAIL %s_latency: %0d clocks, required %0d", name, lat, NIBBLES + 1);
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    check_out(name);
    pulse_ready();
    tests_run++;
    if ({in_ready, out_valid, sl_a, sl_b, sl_cin, sl_m} !== {1'b1, 1'b0, 4'h0, 4'h0, 1'b0, sub}) begin
      failed++;
      $display("FAIL %s_idle: {in_ready,out_valid,sl_a,sl_b,sl_cin,sl_m}=%h, required %h", name,
               {in_ready, out_valid, sl_a, sl_b, sl_cin, sl_m}, {1'b1, 1'b0, 4'h0, 4'h0, 1'b0, sub});
    end
  endtask

  // Scenarios
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("after_reset_release");
  endtask

  task automatic test_vectors;
    run_vec(16'h1234, 16'h0FFF, 1'b0, pack_exp(16'h2233, 1'b0, 1'b0), "add_1234_0fff", 0);
    run_vec(16'h7FFF, 16'h0001, 1'b0, pack_exp(16'h8000, 1'b0, 1'b1), "add_7fff_0001", 0);
    run_vec(16'h0000, 16'h0001, 1'b1, pack_exp(16'hFFFF, 1'b0, 1'b0), "sub_0000_0001", 0);
    run_vec(16'h8000, 16'h0001, 1'b1, pack_exp(16'h7FFF, 1'b1, 1'b1), "sub_8000_0001", 0);
    run_vec(16'hFFFF, 16'h0001, 1'b0, pack_exp(16'h0000, 1'b1, 1'b0), "add_ffff_0001", 1);
  endtask

  task automatic test_backpressure;
    int lat;
    logic [EW-1:0] exp;
    exp = pack_exp(16'h0000, 1'b1, 1'b0);
    drive_req(16'h5A5A, 16'h5A5A, 1'b1);
    exp_q.push_back(exp);
    wait_out(lat);
    // A competing request stays pending while the result is held.
    in_a = 16'h0003; in_b = 16'h0004; in_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({out_valid, in_ready, zero_w, overflow, carry, result} !== {1'b1, 1'b0, exp}) begin
        failed++;
        $display("FAIL hold_stable[%0d]: {out_valid,in_ready,flags,result}=%h, required %h", i,
                 {out_valid, in_ready, zero_w, overflow, carry, result}, {1'b1, 1'b0, exp});
      end
    end
    check_out("sub_5a5a_5a5a");
    pulse_ready();
    exp_q.push_back(pack_exp(16'h0007, 1'b0, 1'b0));
    tests_run++;
    if (in_ready !== 1'b1) begin
      failed++;
      $display("FAIL pending_ready: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin
      failed++;
      $display("FAIL pending_accept: in_ready=%b, required 0", in_ready);
    end
    wait_out(lat);
    check_out("pending_add_3_4");
    pulse_ready();
  endtask

  task automatic test_reset_mid_run;
    drive_req(16'h1111, 16'h2222, 1'b0);
    exp_q.push_back(model(16'h1111, 16'h2222, 1'b0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_run");
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
        failed++;
        $display("FAIL aborted_no_valid[%0d]: out_valid=%b, required 0", i, out_valid);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(16'h0001, 16'h0001, 1'b0, pack_exp(16'h0002, 1'b0, 1'b0), "after_abort_1_1", 0);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a, b;
    logic         sub;
    for (int i = 0; i < 24; i++) begin
      a   = W'($urandom_range(0, (1 << W) - 1));
      b   = W'($urandom_range(0, (1 << W) - 1));
      sub = 1'($urandom_range(0, 1));
      run_vec(a, b, sub, model(a, b, sub), "random", $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
